// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the register-bus round-robin arbiter.
package reg_bus_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [31:0] TimeoutRdata = 32'hBADC_AB1E;
  localparam reg_rsp_t    TimeoutRsp   = '{rdata: TimeoutRdata, error: 1'b1, ready: 1'b1};

endpackage

// File: rtl/reg_bus_arbiter_rr_select.sv
// Combinational round-robin pick: first valid index at or above ptr, wrapping.
module reg_bus_arbiter_rr_select #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              any_valid
);

  int off;
  int best_off;

  // Distance from ptr (mod NumReq) ranks candidates; smallest distance wins.
  always_comb begin
    idx       = '0;
    any_valid = |valid;
    best_off  = NumReq;
    off       = 0;
    for (int i = 0; i < NumReq; i++) begin
      off = i - int'(ptr);
      if (off < 0) off = off + NumReq;
      if (valid[i] && off < best_off) begin
        best_off = off;
        idx      = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register slave between NumReq requesters,
// one transaction in flight, grant locked until response, timeout watchdog.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  reg_req_t [NumReq-1:0]   req_i,
  output reg_rsp_t [NumReq-1:0]   rsp_o,
  output reg_req_t                slv_req_o,
  input  reg_rsp_t                slv_rsp_i,
  output logic     [NumReq-1:0]   grant_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(TimeoutCycles);

  logic [0:0]        state;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   rr_ptr;
  logic [CntW-1:0]   cnt;
  logic [NumReq-1:0] valid_vec;
  logic [IdxW-1:0]   sel_idx;
  logic              any_valid;
  logic              busy;
  logic              tmo;
  logic [IdxW-1:0]   next_ptr;
  reg_req_t          gnt_req;

  for (genvar k = 0; k < NumReq; k++) begin : g_valid
    assign valid_vec[k] = req_i[k].valid;
  end

  reg_bus_arbiter_rr_select #(.NumReq(NumReq), .IdxW(IdxW)) u_rr_select (
    .valid     (valid_vec),
    .ptr       (rr_ptr),
    .idx       (sel_idx),
    .any_valid (any_valid)
  );

  assign gnt_req  = req_i[gnt_idx];
  assign busy     = (state == BUSY);
  // A withdrawn requester gets no response, so timeout only fires while valid is held.
  assign tmo      = busy && gnt_req.valid && !slv_rsp_i.ready &&
                    (cnt == CntW'(TimeoutCycles - 1));
  assign next_ptr = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    slv_req_o = '0;
    rsp_o     = '0;
    grant_o   = '0;
    if (busy) begin
      slv_req_o         = gnt_req;
      slv_req_o.valid   = gnt_req.valid && !tmo;
      rsp_o[gnt_idx]    = tmo ? TimeoutRsp : slv_rsp_i;
      grant_o[gnt_idx]  = 1'b1;
    end
  end

  assign busy_o    = busy;
  assign timeout_o = tmo;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt_idx <= sel_idx;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!gnt_req.valid) begin
            state <= IDLE;
          end else if (slv_rsp_i.ready || tmo) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_reg_bus_arbiter;
  import reg_bus_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  reg_req_t [N-1:0] req;
  reg_rsp_t [N-1:0] rsp;
  reg_req_t         slv_req;
  reg_rsp_t         slv_rsp;
  logic [N-1:0]     grant;
  logic             busy, tmo;

  int n_chk = 0;
  int n_pass = 0;

  reg_bus_arbiter #(.NumReq(N), .TimeoutCycles(TO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .rsp_o     (rsp),
    .slv_req_o (slv_req),
    .slv_rsp_i (slv_rsp),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic reg_req_t mk(input logic [31:0] a, input logic w,
                                  input logic [31:0] d, input logic [3:0] s);
    mk = '{addr: a, write: w, wdata: d, wstrb: s, valid: 1'b1};
  endfunction

  function automatic reg_rsp_t mkr(input logic [31:0] d, input logic e, input logic r);
    mkr = '{rdata: d, error: e, ready: r};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    slv_rsp = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Transaction-level model: who holds the bus, how long it has waited, where the scan starts.
  bit           chk_en = 1'b0;
  bit           m_busy = 1'b0;
  int           m_gnt = 0;
  int           m_ptr = 0;
  int           m_wait = 0;
  bit [N-1:0]   resp_seen = '0;
  reg_req_t     e_req, cur;
  reg_rsp_t [N-1:0] e_rsp;
  logic [N-1:0] e_gnt;
  logic         e_busy, e_tmo;
  bit           found;

  always @(negedge clk) begin
    e_req = '0; e_rsp = '0; e_gnt = '0; e_busy = 1'b0; e_tmo = 1'b0; cur = '0;
    if (m_busy) begin
      cur = req[IW'(m_gnt)];
      e_busy = 1'b1;
      e_gnt = N'(1) << m_gnt;
      e_req = cur;
      e_rsp[IW'(m_gnt)] = slv_rsp;
      if (cur.valid && !slv_rsp.ready && m_wait == TO - 1) begin
        e_tmo = 1'b1;
        e_req.valid = 1'b0;
        e_rsp[IW'(m_gnt)] = mkr(32'hBADC_AB1E, 1'b1, 1'b1);
      end
    end
    if (chk_en) begin
      chk("model_slv_req", 128'(slv_req), 128'(e_req));
      chk("model_rsp",     128'(rsp),     128'(e_rsp));
      chk("model_grant",   128'(grant),   128'(e_gnt));
      chk("model_busy",    128'(busy),    128'(e_busy));
      chk("model_timeout", 128'(tmo),     128'(e_tmo));
    end
    resp_seen = '0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr = 0;
    end else if (m_busy) begin
      if (!cur.valid) m_busy = 1'b0;
      else if (slv_rsp.ready || e_tmo) begin
        resp_seen[IW'(m_gnt)] = 1'b1;
        m_ptr = (m_gnt + 1) % N;
        m_busy = 1'b0;
      end else m_wait++;
    end else begin
      found = 1'b0;
      for (int o = 0; o < N; o++) begin
        if (!found && req[IW'((m_ptr + o) % N)].valid) begin
          m_gnt = (m_ptr + o) % N;
          found = 1'b1;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_wait = 0;
      end
    end
  end

  reg_req_t w3;
  int busy_cnt;

  initial begin
    req = '0;
    slv_rsp = '0;
    rst_n = 1'b0;
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_grant",   128'(grant),   128'(0));
    chk("reset_busy",    128'(busy),    128'(0));
    chk("reset_timeout", 128'(tmo),     128'(0));
    chk("reset_slv_req", 128'(slv_req), 128'(0));
    chk("reset_rsp",     128'(rsp),     128'(0));
    cyc();
    rst_n = 1'b1;

    // Single request, zero-wait slave
    req[0] = mk(32'h4, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    chk("single_c0_grant", 128'(grant), 128'(0));
    cyc();
    slv_rsp = mkr(32'h1234, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_c1_rsp0",  128'(rsp[0]),       128'(mkr(32'h1234, 1'b0, 1'b1)));
    chk("single_c1_grant", 128'(grant),        128'(3'b001));
    chk("single_c1_addr",  128'(slv_req.addr), 128'(32'h4));
    cyc();
    req[0].valid = 1'b0;
    slv_rsp = '0;
    @(negedge clk);
    chk("single_c2_busy", 128'(busy), 128'(0));

    // Contention between req0 and req1, zero-wait slave
    do_reset();
    req[0] = mk(32'h10, 1'b0, 32'h0, 4'h0);
    req[1] = mk(32'h20, 1'b0, 32'h0, 4'h0);
    slv_rsp = mkr(32'h0, 1'b0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk($sformatf("contend_c%0d_grant", t), 128'(grant),
          128'((t % 2 == 0) ? 3'b000 : ((t % 4 == 1) ? 3'b001 : 3'b010)));
      cyc();
    end

    // Wait states: five not-ready cycles then completion
    do_reset();
    w3 = mk(32'h40, 1'b1, 32'hCAFE_F00D, 4'hF);
    req[1] = w3;
    busy_cnt = 0;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (t >= 1 && t <= 6) begin
        chk($sformatf("wait_c%0d_fwd", t),   128'(slv_req),      128'(w3));
        chk($sformatf("wait_c%0d_ready", t), 128'(rsp[1].ready), 128'(t == 6));
      end
      cyc();
      if (t == 5) slv_rsp = mkr(32'h77, 1'b0, 1'b1);
      if (t == 6) begin slv_rsp = '0; req[1].valid = 1'b0; end
    end
    chk("wait_busy_cycles", 128'(busy_cnt), 128'(6));

    // Timeout with a dead slave; next grant goes to the other requester
    do_reset();
    req[0] = mk(32'h80, 1'b0, 32'h0, 4'h0);
    req[1] = mk(32'h84, 1'b0, 32'h0, 4'h0);
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      if (t == 7) chk("tmo_c7_pulse", 128'(tmo), 128'(0));
      if (t == 8) begin
        chk("tmo_c8_rsp0",  128'(rsp[0]),        128'(mkr(32'hBADC_AB1E, 1'b1, 1'b1)));
        chk("tmo_c8_pulse", 128'(tmo),           128'(1));
        chk("tmo_c8_valid", 128'(slv_req.valid), 128'(0));
      end
      if (t == 9) begin
        chk("tmo_c9_pulse", 128'(tmo),  128'(0));
        chk("tmo_c9_busy",  128'(busy), 128'(0));
      end
      if (t == 10) chk("tmo_c10_grant", 128'(grant), 128'(3'b010));
      cyc();
      if (t == 8) req[0].valid = 1'b0;
    end

    // Ready arrives exactly on the last allowed cycle
    do_reset();
    req[0] = mk(32'h90, 1'b0, 32'h0, 4'h0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t == 8) begin
        chk("edge_c8_rsp0",  128'(rsp[0]), 128'(mkr(32'h55AA, 1'b0, 1'b1)));
        chk("edge_c8_pulse", 128'(tmo),    128'(0));
      end
      if (t == 9) chk("edge_c9_busy", 128'(busy), 128'(0));
      cyc();
      if (t == 7) slv_rsp = mkr(32'h55AA, 1'b0, 1'b1);
      if (t == 8) begin slv_rsp = '0; req[0].valid = 1'b0; end
    end

    // Reset during a wait state after the pointer has moved to 2
    do_reset();
    req[1] = mk(32'hA0, 1'b0, 32'h0, 4'h0);
    slv_rsp = mkr(32'h0, 1'b0, 1'b1);
    cyc();
    cyc();
    req[1].valid = 1'b0;
    req[2] = mk(32'hB0, 1'b0, 32'h0, 4'h0);
    slv_rsp = '0;
    cyc();
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_c4_grant", 128'(grant), 128'(3'b100));
    cyc();
    rst_n = 1'b1;
    req[0] = mk(32'hC0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rstmid_c5_grant", 128'(grant), 128'(0));
    chk("rstmid_c5_busy",  128'(busy),  128'(0));
    chk("rstmid_c5_rsp",   128'(rsp),   128'(0));
    cyc();
    @(negedge clk);
    chk("rstmid_c6_grant", 128'(grant), 128'(3'b001));

    // Randomized traffic: requesters hold until answered or occasionally withdraw
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cyc();
      rst_n = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < N; k++) begin
        if (req[k].valid) begin
          if (resp_seen[k] || $urandom_range(0, 49) == 0) req[k].valid = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[k] = mk($urandom, 1'($urandom), $urandom, 4'($urandom));
        end
      end
      slv_rsp.rdata = $urandom;
      slv_rsp.error = ($urandom_range(0, 9) == 0);
      slv_rsp.ready = ($urandom_range(0, 99) < 30);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
